// File: rtl/sram_bootrom_loader_pkg.sv
// Shared definitions for the boot ROM loader: SRAM address width, default
// ROM placement and the loader FSM state encoding.
package sram_bootrom_loader_pkg;

    localparam int SRAM_AW = 19;
    localparam logic [SRAM_AW-1:0] ROM_BASE_DEFAULT = 19'h70000;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/sram_bootrom_loader_if.sv
// Bus bundle around the loader.
//   host side : host_reset, host_bootdata, host_bootdata_req/ack (4-phase)
//   machine   : sam_addr, sam_we_n
//   SRAM pins : sram_addr, sram_we_n, sram_dout, sram_dout_oe
//   status    : rom_initialised
// master = host/machine/top level, slave = the loader.
interface sram_bootrom_loader_if;
    import sram_bootrom_loader_pkg::*;

    logic               host_reset;
    logic [31:0]        host_bootdata;
    logic               host_bootdata_req;
    logic               host_bootdata_ack;
    logic [SRAM_AW-1:0] sam_addr;
    logic               sam_we_n;
    logic [SRAM_AW-1:0] sram_addr;
    logic               sram_we_n;
    logic [7:0]         sram_dout;
    logic               sram_dout_oe;
    logic               rom_initialised;

    modport master (
        output host_reset, host_bootdata, host_bootdata_req, sam_addr, sam_we_n,
        input  host_bootdata_ack, sram_addr, sram_we_n, sram_dout, sram_dout_oe,
               rom_initialised
    );

    modport slave (
        input  host_reset, host_bootdata, host_bootdata_req, sam_addr, sam_we_n,
        output host_bootdata_ack, sram_addr, sram_we_n, sram_dout, sram_dout_oe,
               rom_initialised
    );

endinterface

// File: rtl/sram_bootrom_loader_port_mux.sv
// sram_port_mux: hands the SRAM address / write strobe to either the loader
// or the machine. Purely combinational.
//   i_sel       1 = machine owns SRAM (rom_initialised)
//   i_ldr_*     loader address / strobe
//   i_sam_*     machine address / strobe
//   o_addr/o_we_n  to the SRAM pins
module sram_port_mux
    import sram_bootrom_loader_pkg::*;
(
    input  logic               i_sel,
    input  logic [SRAM_AW-1:0] i_ldr_addr,
    input  logic               i_ldr_we_n,
    input  logic [SRAM_AW-1:0] i_sam_addr,
    input  logic               i_sam_we_n,
    output logic [SRAM_AW-1:0] o_addr,
    output logic               o_we_n
);

    assign o_addr = i_sel ? i_sam_addr : i_ldr_addr;
    assign o_we_n = i_sel ? i_sam_we_n : i_ldr_we_n;

endmodule

// File: rtl/sram_bootrom_loader.sv
// sram_bootrom_loader: takes 32-bit boot words over a 4-phase req/ack
// handshake, writes each as four bytes (MSB first) into SRAM starting at
// ROM_BASE, then raises rom_initialised and gives the SRAM port to the machine.
//   clk      system clock
//   reset_n  async active-low reset
//   bus      slave side of sram_bootrom_loader_if (host, machine, SRAM pins)
// Parameters: ROM_BASE (SRAM byte address of ROM byte 0), ROM_BYTES (image
// length, multiple of 4), WE_CYCLES (we_n low time per byte, 1..7).
module sram_bootrom_loader
    import sram_bootrom_loader_pkg::*;
#(
    parameter logic [SRAM_AW-1:0] ROM_BASE  = ROM_BASE_DEFAULT,
    parameter int                 ROM_BYTES = 32768,
    parameter int                 WE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    sram_bootrom_loader_if.slave  bus
);

    localparam int CW = $clog2(ROM_BYTES) + 1;
    localparam logic [CW-1:0] ROM_BYTES_C = CW'(ROM_BYTES);
    localparam logic [2:0]    WE_LAST     = 3'(WE_CYCLES - 1);

    state_t       r_state;
    logic [CW-1:0] r_count;
    logic [1:0]   r_byte_idx;
    logic [2:0]   r_we_cnt;
    logic [23:0]  r_word;      // bytes still to be written, next one at [23:16]
    logic [7:0]   r_dout;
    logic         r_ack;
    logic         r_we_n;
    logic         r_oe;
    logic         r_rom_init;

    logic [CW-1:0]      w_count_nxt;
    logic               w_take;
    logic [SRAM_AW-1:0] w_ldr_addr;
    logic               w_ldr_we_n;
    logic [SRAM_AW-1:0] w_addr;
    logic               w_we_n;

    assign w_count_nxt = r_count + 1'b1;
    assign w_take      = bus.host_bootdata_req && !r_ack;
    assign w_ldr_addr  = ROM_BASE + SRAM_AW'(r_count);
    // host_reset kills an in-flight strobe immediately, not one cycle later
    assign w_ldr_we_n  = r_we_n | bus.host_reset;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_byte_idx <= '0;
            r_we_cnt   <= '0;
            r_word     <= '0;
            r_dout     <= '0;
            r_ack      <= 1'b0;
            r_we_n     <= 1'b1;
            r_oe       <= 1'b0;
            r_rom_init <= 1'b0;
        end else if (bus.host_reset) begin
            // any req seen this cycle is dropped; the host re-presents it
            r_state    <= IDLE;
            r_count    <= '0;
            r_byte_idx <= '0;
            r_we_cnt   <= '0;
            r_ack      <= 1'b0;
            r_we_n     <= 1'b1;
            r_oe       <= 1'b0;
            r_rom_init <= 1'b0;
        end else begin
            // ack falls in any state once req is released
            if (r_ack && !bus.host_bootdata_req)
                r_ack <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_ack      <= 1'b1;
                        r_dout     <= bus.host_bootdata[31:24];
                        r_word     <= bus.host_bootdata[23:0];
                        r_byte_idx <= 2'd0;
                        r_oe       <= 1'b1;
                        r_we_n     <= 1'b1;
                        r_state    <= SETUP;
                    end
                end
                SETUP: begin
                    r_we_n   <= 1'b0;
                    r_we_cnt <= '0;
                    r_state  <= WRITE;
                end
                WRITE: begin
                    if (r_we_cnt == WE_LAST) begin
                        r_we_n  <= 1'b1;
                        r_state <= HOLD;
                    end else begin
                        r_we_cnt <= r_we_cnt + 3'd1;
                    end
                end
                HOLD: begin
                    r_count <= w_count_nxt;
                    if (r_byte_idx != 2'd3) begin
                        r_byte_idx <= r_byte_idx + 2'd1;
                        r_dout     <= r_word[23:16];
                        r_word     <= {r_word[15:0], 8'h00};
                        r_state    <= SETUP;
                    end else if (w_count_nxt == ROM_BYTES_C) begin
                        r_oe       <= 1'b0;
                        r_rom_init <= 1'b1;
                        r_state    <= DONE;
                    end else begin
                        r_oe    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                DONE: begin
                    // late words are acked and thrown away
                    if (w_take)
                        r_ack <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sram_port_mux u_mux (
        .i_sel      (r_rom_init),
        .i_ldr_addr (w_ldr_addr),
        .i_ldr_we_n (w_ldr_we_n),
        .i_sam_addr (bus.sam_addr),
        .i_sam_we_n (bus.sam_we_n),
        .o_addr     (w_addr),
        .o_we_n     (w_we_n)
    );

    assign bus.sram_addr         = w_addr;
    assign bus.sram_we_n         = w_we_n;
    assign bus.sram_dout         = r_dout;
    assign bus.sram_dout_oe      = r_oe;
    assign bus.host_bootdata_ack = r_ack;
    assign bus.rom_initialised   = r_rom_init;

endmodule

// File: tb/tb_sram_bootrom_loader.sv
// Bench for sram_bootrom_loader with ROM_BYTES=16, WE_CYCLES=2.
// A negedge monitor turns every loader write pulse into {addr, data, width}
// and pops the expected write from a scoreboard queue filled as words are sent.
module tb_sram_bootrom_loader;

    localparam logic [18:0] RB = 19'h70000;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  b0, b1, b2, b3;
    } wvec_t;

    typedef struct {
        logic [18:0] sam_addr;
        logic        sam_we_n;
        logic [18:0] exp_addr;
        logic        exp_we_n;
    } mvec_t;

    typedef struct {
        logic [18:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;
    int   n_fall = 0;
    int   mcnt = 0;
    wr_t  exp_q[$];

    sram_bootrom_loader_if bus();

    sram_bootrom_loader #(.ROM_BYTES(16), .WE_CYCLES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d);
        wr_t e;
        e.addr = RB + 19'(mcnt);
        e.data = d;
        exp_q.push_back(e);
        mcnt++;
    endtask

    // write monitor
    initial begin
        int          low_cnt;
        logic [18:0] cap_addr;
        logic [7:0]  cap_dat;
        wr_t         e;
        low_cnt = 0;
        cap_addr = '0;
        cap_dat = '0;
        forever begin
            @(negedge clk);
            if (!reset_n || bus.rom_initialised) begin
                low_cnt = 0;
            end else if (!bus.sram_we_n) begin
                if (low_cnt == 0) begin
                    cap_addr = bus.sram_addr;
                    cap_dat  = bus.sram_dout;
                    n_fall++;
                    chk("oe_during_we", bus.sram_dout_oe, 1);
                end
                low_cnt++;
            end else if (low_cnt > 0) begin
                if (!bus.host_reset) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", {13'h0, cap_addr}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", {13'h0, cap_addr}, {13'h0, e.addr});
                        chk("wr_data", {24'h0, cap_dat}, {24'h0, e.data});
                        chk("wr_width", low_cnt, 2);
                    end
                end
                low_cnt = 0;
            end
        end
    end

    // send one word; lat = negedges from ack seen to oe falling
    task automatic run_word(input logic [31:0] d, input logic [7:0] b0, b1, b2, b3,
                            output int lat);
        bit got;
        lat = -1;
        push_exp(b0); push_exp(b1); push_exp(b2); push_exp(b3);
        @(posedge clk); #1;
        bus.host_bootdata = d;
        bus.host_bootdata_req = 1'b1;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.host_bootdata_ack) got = 1;
        end
        chk("ack_rise", got, 1);
        if (!got) begin
            bus.host_bootdata_req = 1'b0;
            return;
        end
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) bus.host_bootdata_req = 1'b0;
            @(negedge clk);
            if (i == 2) chk("ack_fall", bus.host_bootdata_ack, 0);
            if (!bus.sram_dout_oe) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_ack(input logic v, input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.host_bootdata_ack == v) got = 1;
        end
        chk(name, got, 1);
    endtask

    initial begin
        wvec_t wtab[4];
        mvec_t mtab[4];
        int    lat, base, ack_low, oe_hi;
        bit    got;

        wtab[0] = '{32'h01234567, 8'h01, 8'h23, 8'h45, 8'h67};
        wtab[1] = '{32'h89ABCDEF, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        wtab[2] = '{32'hFF00FF00, 8'hFF, 8'h00, 8'hFF, 8'h00};
        wtab[3] = '{32'h5AA5C33C, 8'h5A, 8'hA5, 8'hC3, 8'h3C};
        mtab[0] = '{19'h12345, 1'b1, 19'h12345, 1'b1};
        mtab[1] = '{19'h12345, 1'b0, 19'h12345, 1'b0};
        mtab[2] = '{19'h7FFFF, 1'b0, 19'h7FFFF, 1'b0};
        mtab[3] = '{19'h00000, 1'b1, 19'h00000, 1'b1};

        bus.host_reset = 1'b0;
        bus.host_bootdata = '0;
        bus.host_bootdata_req = 1'b0;
        bus.sam_addr = 19'h12345;
        bus.sam_we_n = 1'b0;   // must be ignored until the ROM is loaded

        // reset release, no req
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        ack_low = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.host_bootdata_ack) ack_low++;
        end
        chk("rst_ack_never", ack_low, 0);
        chk("rst_rom_init", bus.rom_initialised, 0);
        chk("rst_we_n", bus.sram_we_n, 1);
        chk("rst_oe", bus.sram_dout_oe, 0);
        chk("rst_dout", bus.sram_dout, 0);
        chk("rst_addr", bus.sram_addr, RB);

        // single word, byte order and 16-cycle latency
        run_word(32'hDEADBEEF, 8'hDE, 8'hAD, 8'hBE, 8'hEF, lat);
        chk("deadbeef_latency", lat, 16);
        chk("deadbeef_rom_init", bus.rom_initialised, 0);

        // req held high: no second latch, ack held
        push_exp(8'h11); push_exp(8'h22); push_exp(8'h33); push_exp(8'h44);
        base = n_fall;
        @(posedge clk); #1;
        bus.host_bootdata = 32'h11223344;
        bus.host_bootdata_req = 1'b1;
        wait_ack(1'b1, "held_ack_rise");
        ack_low = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!bus.host_bootdata_ack) ack_low++;
        end
        chk("held_ack_stays", ack_low, 0);
        chk("held_single_latch", n_fall - base, 4);
        @(posedge clk); #1;
        bus.host_bootdata_req = 1'b0;
        @(negedge clk);
        chk("held_ack_before_sample", bus.host_bootdata_ack, 1);
        @(negedge clk);
        chk("held_ack_dropped", bus.host_bootdata_ack, 0);

        run_word(32'h55667788, 8'h55, 8'h66, 8'h77, 8'h88, lat);
        chk("reraise_latency", lat, 16);

        // host_reset in WRITE of byte 2: only bytes 0 and 1 complete
        push_exp(8'hA1); push_exp(8'hB2);
        base = n_fall;
        @(posedge clk); #1;
        bus.host_bootdata = 32'hA1B2C3D4;
        bus.host_bootdata_req = 1'b1;
        wait_ack(1'b1, "abort_ack_rise");
        @(posedge clk); #1;
        bus.host_bootdata_req = 1'b0;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (n_fall >= base + 3) begin
                got = 1;
                break;
            end
        end
        chk("abort_reach_byte2", got, 1);
        #1;
        bus.host_reset = 1'b1;
        #1;
        chk("abort_we_same_cycle", bus.sram_we_n, 1);
        @(posedge clk); #1;
        bus.host_reset = 1'b0;
        mcnt = 0;
        @(negedge clk);
        chk("hr_ack", bus.host_bootdata_ack, 0);
        chk("hr_oe", bus.sram_dout_oe, 0);
        chk("hr_rom_init", bus.rom_initialised, 0);
        chk("hr_addr", bus.sram_addr, RB);

        // req rising together with host_reset is not latched
        @(posedge clk); #1;
        bus.host_reset = 1'b1;
        bus.host_bootdata = 32'hBADBAD00;
        bus.host_bootdata_req = 1'b1;
        @(posedge clk); #1;
        bus.host_reset = 1'b0;
        bus.host_bootdata_req = 1'b0;
        @(negedge clk);
        chk("simul_no_ack", bus.host_bootdata_ack, 0);
        chk("simul_no_oe", bus.sram_dout_oe, 0);

        // full reload: four table words, rom_initialised on the last
        for (int k = 0; k < 4; k++) begin
            run_word(wtab[k].word, wtab[k].b0, wtab[k].b1, wtab[k].b2, wtab[k].b3, lat);
            chk($sformatf("load%0d_latency", k), lat, 16);
            chk($sformatf("load%0d_rom_init", k), bus.rom_initialised, (k == 3) ? 1 : 0);
        end

        // machine owns the port
        for (int k = 0; k < 4; k++) begin
            bus.sam_addr = mtab[k].sam_addr;
            bus.sam_we_n = mtab[k].sam_we_n;
            #1;
            chk($sformatf("mux%0d_addr", k), bus.sram_addr, mtab[k].exp_addr);
            chk($sformatf("mux%0d_we_n", k), bus.sram_we_n, mtab[k].exp_we_n);
            @(negedge clk);
        end

        // word after DONE: handshake completes, nothing written
        base = n_fall;
        @(posedge clk); #1;
        bus.host_bootdata = 32'hCAFEF00D;
        bus.host_bootdata_req = 1'b1;
        wait_ack(1'b1, "done_ack_rise");
        @(posedge clk); #1;
        bus.host_bootdata_req = 1'b0;
        wait_ack(1'b0, "done_ack_fall");
        oe_hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.sram_dout_oe) oe_hi++;
        end
        chk("done_no_oe", oe_hi, 0);
        chk("done_no_write", n_fall - base, 0);
        chk("done_rom_init", bus.rom_initialised, 1);
        bus.sam_we_n = 1'b0;
        #1;
        chk("done_we_tracks", bus.sram_we_n, 0);

        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
